gpsreceiver2_capture_ctl: RTL and testbench
===========================================

// Module: gpsreceiver2_capture_ctl
// PURPOSE
//  Parametrised successor to the single-bank GPS sample address counter. Generates write
//  strobes and addresses for a multi-bank sample RAM, with decimation, one-shot/continuous/
//  ping-pong modes, per-bank ready flags with host ack, and sticky overflow detection.
//  Sits between the RF front-end sample strobe and the buffer RAM; status goes to the CSR block.
// PARAMETERS
//  ADR_W    11  address bits per bank (bank depth = 2**ADR_W)
//  BANKS    2   number of banks; 2, 4 or 8 only
//  DECIM_W  4   width of decimation ratio field
//  (localparam BANK_W = $clog2(BANKS))
// PORTS
//  sys_clk     in   1               single clock for all logic
//  sys_rst     in   1               asynchronous, active-high reset
//  r_enable    in   1               level; run capture while 1
//  r_clear     in   1               synchronous clear pulse
//  r_mode      in   2               00 one-shot, 01 continuous, 10 ping-pong, 11 = one-shot
//  r_decim     in   DECIM_W         keep 1 of every r_decim+1 accepted strobes
//  sample_stb  in   1               one cycle per incoming sample
//  bank_ack    in   BANKS           host release, one-cycle pulse per bank bit
//  buf_we      out  1               RAM write enable (registered)
//  buf_adr     out  BANK_W+ADR_W    {bank, offset} RAM address (registered)
//  rx_count    out  ADR_W+1         samples written into current bank, 0..2**ADR_W
//  bank_ready  out  BANKS           bit set = bank full, awaiting host
//  bank_done   out  1               one-cycle pulse when a bank fills
//  overflow    out  1               sticky; samples dropped
//  busy        out  1               state is RUN or WAIT
// BEHAVIOUR
//  - Reset (sys_rst): state IDLE; all outputs, offset, bank, decimator = 0.
//  - States: IDLE, RUN, WAIT, DONE.
//    IDLE: r_enable=1 -> RUN; offset/bank retained (pause/resume), decimator cleared.
//    RUN: r_enable=0 -> IDLE. Strobe counted only in RUN; when decim count == r_decim,
//      next cycle buf_we=1 with buf_adr={bank,offset}; decim count -> 0, offset+1, rx_count+1.
//      Latency sample_stb -> buf_we = 1 cycle. r_decim=0 writes every strobe.
//    Last write of bank (offset == 2**ADR_W-1), in the write cycle:
//      bank_ready[bank] set, bank_done pulse, rx_count = 2**ADR_W for that cycle only
//      (back to 0 next cycle, except in DONE).
//      one-shot: -> DONE, offset wraps to 0.
//      continuous: offset wraps to 0, same bank, stay RUN; ready bit re-set each fill.
//      ping-pong: bank <- bank+1 mod BANKS, offset 0; if bank_ready[next] still 1 (not
//        acked) -> overflow=1, WAIT.
//    WAIT: strobes dropped (no buf_we); bank_ack of waited bank -> RUN next cycle;
//      r_enable=0 -> IDLE.
//    DONE: holds everything; r_enable ignored; only r_clear/sys_rst leave.
//  - bank_ack[i] clears bank_ready[i]; set and ack on same bit in same cycle: set wins.
//  - r_clear: highest sync priority; same effect as sys_rst, overrides strobe/ack that cycle.
//  - r_mode and r_decim sampled continuously; changing them in RUN is legal,
//    takes effect on next strobe; no glitch on buf_we.
//  - Offset/bank arithmetic is modular (natural wrap); no write ever exceeds bank bounds.
// STRUCTURE
//  - Shared include gpsreceiver2_defs.vh: mode encodings (MODE_ONESHOT/CONT/PINGPONG),
//    FSM state encodings.
//  - One sub-module: gpsreceiver2_decimator (DECIM_W counter, outputs keep strobe, clear input).
//  - Remainder (FSM, offset/bank counters, ready/overflow flags) in this module.
// TESTING
//  1 ADR_W=3, one-shot, r_decim=0, 8 strobes -> buf_adr 0..7, bank_done on 8th write,
//    bank_ready=01, DONE; 9th strobe -> no buf_we.
//  2 r_decim=2, 9 strobes -> 3 writes (strobes 3,6,9), addresses 0,1,2, rx_count=3.
//  3 Ping-pong BANKS=2, no ack, 17 strobes -> bank0 then bank1 fill, overflow=1, WAIT;
//    17th strobe dropped; bank_ack=01 -> RUN, next strobe writes {0,000}.
//  4 Continuous, 20 strobes -> offsets wrap 7->0 in bank0, two bank_done pulses.
//  5 r_enable dropped after 3 writes, 5 strobes while IDLE, re-enable -> next write adr 3.
//  6 r_clear coincident with sample_stb and bank_ack mid-RUN -> no buf_we, all outputs 0,
//    IDLE; sys_rst asserted mid-write clears buf_we asynchronously.

Source files
------------

// File: rtl/gpsreceiver2_capture_ctl_pkg.sv
// Shared encodings for the GPS sample capture controller:
// capture modes and FSM states.
package gpsreceiver2_capture_ctl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_CONT     = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;

   // Encoding 11 is treated as one-shot.
   function automatic logic is_oneshot(input logic [1:0] m);
      return (m == MODE_ONESHOT) || (m == 2'b11);
   endfunction

endpackage

// File: rtl/gpsreceiver2_decimator.sv
// Strobe decimator: passes 1 of every ratio+1 input strobes.
// keep is combinational so the write lands one cycle after the strobe.
module gpsreceiver2_decimator #(
   parameter int DECIM_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               stb,
   input  logic [DECIM_W-1:0] ratio,
   output logic               keep
);

   logic [DECIM_W-1:0] cnt;

   // >= keeps a lowered ratio from forcing a full counter wrap
   assign keep = stb && (cnt >= ratio);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (stb) begin
         cnt <= keep ? '0 : cnt + DECIM_W'(1);
      end
   end

endmodule

// File: rtl/gpsreceiver2_capture_ctl.sv
// Multi-bank sample RAM capture controller: write strobes/addresses,
// one-shot/continuous/ping-pong modes, bank ready flags, overflow.
module gpsreceiver2_capture_ctl
   import gpsreceiver2_capture_ctl_pkg::*;
#(
   parameter int ADR_W   = 11,
   parameter int BANKS   = 2,
   parameter int DECIM_W = 4
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     r_enable,
   input  logic                     r_clear,
   input  logic [1:0]               r_mode,
   input  logic [DECIM_W-1:0]       r_decim,
   input  logic                     sample_stb,
   input  logic [BANKS-1:0]         bank_ack,
   output logic                     buf_we,
   output logic [$clog2(BANKS)+ADR_W-1:0] buf_adr,
   output logic [ADR_W:0]           rx_count,
   output logic [BANKS-1:0]         bank_ready,
   output logic                     bank_done,
   output logic                     overflow,
   output logic                     busy
);

   localparam int BANK_W = $clog2(BANKS);

   logic [1:0]        state;
   logic [ADR_W-1:0]  offset;
   logic [BANK_W-1:0] bank;
   logic [BANK_W-1:0] nxt_bank;
   logic [BANKS-1:0]  rdy_nxt;
   logic              run_act;
   logic              keep;
   logic              last;
   logic              nxt_busy;

   assign run_act  = (state == ST_RUN) && r_enable;
   assign last     = (offset == '1);
   assign nxt_bank = bank + BANK_W'(1);
   assign nxt_busy = bank_ready[nxt_bank] && !bank_ack[nxt_bank];
   assign busy     = (state == ST_RUN) || (state == ST_WAIT);

   gpsreceiver2_decimator #(
      .DECIM_W (DECIM_W)
   ) u_decim (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (r_clear || (state == ST_IDLE)),
      .stb   (sample_stb && run_act),
      .ratio (r_decim),
      .keep  (keep)
   );

   // A fill in the same cycle as an ack of that bank keeps it ready
   always_comb begin
      rdy_nxt = bank_ready & ~bank_ack;
      if (keep && last) rdy_nxt[bank] = 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         offset     <= '0;
         bank       <= '0;
         buf_we     <= 1'b0;
         buf_adr    <= '0;
         rx_count   <= '0;
         bank_ready <= '0;
         bank_done  <= 1'b0;
         overflow   <= 1'b0;
      end else if (r_clear) begin
         state      <= ST_IDLE;
         offset     <= '0;
         bank       <= '0;
         buf_we     <= 1'b0;
         buf_adr    <= '0;
         rx_count   <= '0;
         bank_ready <= '0;
         bank_done  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         buf_we     <= keep;
         bank_done  <= keep && last;
         bank_ready <= rdy_nxt;
         if (keep) begin
            buf_adr  <= {bank, offset};
            offset   <= offset + ADR_W'(1);
            rx_count <= {1'b0, offset} + (ADR_W+1)'(1);
         end else if (rx_count[ADR_W] && state != ST_DONE) begin
            rx_count <= '0;
         end
         unique case (state)
            ST_IDLE: if (r_enable) state <= ST_RUN;
            ST_RUN: begin
               if (!r_enable) begin
                  state <= ST_IDLE;
               end else if (keep && last) begin
                  if (is_oneshot(r_mode)) begin
                     state <= ST_DONE;
                  end else if (r_mode == MODE_PINGPONG) begin
                     bank <= nxt_bank;
                     if (nxt_busy) begin
                        overflow <= 1'b1;
                        state    <= ST_WAIT;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (!r_enable) state <= ST_IDLE;
               else if (bank_ack[bank]) state <= ST_RUN;
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpsreceiver2_capture_ctl.sv
// Scoreboard bench for gpsreceiver2_capture_ctl with 8-deep banks:
// expected write addresses queued at strobe time, popped on buf_we.
module tb_gpsreceiver2_capture_ctl;

   localparam int ADR_W   = 3;
   localparam int BANKS   = 2;
   localparam int DECIM_W = 4;
   localparam int AW      = 1 + ADR_W;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               r_enable = 1'b0;
   logic               r_clear = 1'b0;
   logic [1:0]         r_mode = 2'b00;
   logic [DECIM_W-1:0] r_decim = '0;
   logic               sample_stb = 1'b0;
   logic [BANKS-1:0]   bank_ack = '0;
   logic               buf_we;
   logic [AW-1:0]      buf_adr;
   logic [ADR_W:0]     rx_count;
   logic [BANKS-1:0]   bank_ready;
   logic               bank_done;
   logic               overflow;
   logic               busy;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [AW-1:0] sb_q[$];

   gpsreceiver2_capture_ctl #(
      .ADR_W   (ADR_W),
      .BANKS   (BANKS),
      .DECIM_W (DECIM_W)
   ) dut (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .r_enable   (r_enable),
      .r_clear    (r_clear),
      .r_mode     (r_mode),
      .r_decim    (r_decim),
      .sample_stb (sample_stb),
      .bank_ack   (bank_ack),
      .buf_we     (buf_we),
      .buf_adr    (buf_adr),
      .rx_count   (rx_count),
      .bank_ready (bank_ready),
      .bank_done  (bank_done),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bank_done) done_cnt++;
      if (buf_we) begin
         chk("we_expected", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) chk("we_adr", buf_adr, sb_q.pop_front());
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one strobe, then one quiet cycle; returns where its write is visible
   task automatic stb(input logic exp_wr, input logic [AW-1:0] adr);
      @(negedge clk);
      sample_stb = 1'b1;
      if (exp_wr) sb_q.push_back(adr);
      @(negedge clk);
      sample_stb = 1'b0;
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      chk(tag, sb_q.size(), 0);
   endtask

   task automatic start(input logic [1:0] m, input logic [DECIM_W-1:0] d);
      @(negedge clk);
      r_enable = 1'b0;
      r_clear  = 1'b1;
      @(negedge clk);
      r_clear  = 1'b0;
      r_mode   = m;
      r_decim  = d;
      r_enable = 1'b1;
      idle(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      idle(3);
      rst = 1'b0;
      idle(1);
      chk("rst_we", buf_we, 0);
      chk("rst_adr", buf_adr, 0);
      chk("rst_cnt", rx_count, 0);
      chk("rst_rdy", bank_ready, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);

      // one-shot, every strobe
      start(2'b00, 0);
      for (int i = 0; i < 8; i++) stb(1'b1, AW'(i));
      chk("t1_done", bank_done, 1);
      chk("t1_cnt8", rx_count, 8);
      chk("t1_rdy", bank_ready, 2'b01);
      chk("t1_busy", busy, 0);
      stb(1'b0, '0);
      chk("t1_hold", rx_count, 8);
      drain("t1_q");
      chk("t1_ndone", done_cnt, 1);

      // decimate by 3
      start(2'b01, 2);
      for (int i = 1; i <= 9; i++) stb(i % 3 == 0, AW'(i / 3 - 1));
      chk("t2_cnt", rx_count, 3);
      drain("t2_q");

      // ping-pong without ack
      start(2'b10, 0);
      for (int i = 0; i < 8; i++) stb(1'b1, AW'(i));
      chk("t3_rdy0", bank_ready, 2'b01);
      chk("t3_ovf0", overflow, 0);
      for (int i = 8; i < 16; i++) stb(1'b1, AW'(i));
      chk("t3_rdy", bank_ready, 2'b11);
      chk("t3_ovf", overflow, 1);
      chk("t3_wait", busy, 1);
      stb(1'b0, '0);
      @(negedge clk);
      bank_ack = 2'b01;
      @(negedge clk);
      bank_ack = 2'b00;
      chk("t3_ackrdy", bank_ready, 2'b10);
      stb(1'b1, AW'(0));
      chk("t3_sticky", overflow, 1);
      drain("t3_q");

      // continuous wrap
      start(2'b01, 0);
      d0 = done_cnt;
      for (int i = 0; i < 20; i++) stb(1'b1, AW'(i % 8));
      drain("t4_q");
      chk("t4_ndone", done_cnt - d0, 2);
      chk("t4_rdy", bank_ready, 2'b01);

      // pause / resume
      start(2'b01, 0);
      for (int i = 0; i < 3; i++) stb(1'b1, AW'(i));
      r_enable = 1'b0;
      idle(1);
      chk("t5_idle", busy, 0);
      for (int i = 0; i < 5; i++) stb(1'b0, '0);
      r_enable = 1'b1;
      idle(1);
      stb(1'b1, AW'(3));
      chk("t5_cnt", rx_count, 4);
      drain("t5_q");

      // clear beats strobe and ack
      start(2'b10, 0);
      for (int i = 0; i < 8; i++) stb(1'b1, AW'(i));
      stb(1'b1, AW'(8));
      drain("t6_q0");
      @(negedge clk);
      sample_stb = 1'b1;
      r_clear = 1'b1;
      bank_ack = 2'b11;
      @(negedge clk);
      sample_stb = 1'b0;
      r_clear = 1'b0;
      bank_ack = 2'b00;
      chk("t6_we", buf_we, 0);
      chk("t6_adr", buf_adr, 0);
      chk("t6_cnt", rx_count, 0);
      chk("t6_rdy", bank_ready, 0);
      chk("t6_busy", busy, 0);

      // async reset during a write
      idle(1);
      @(negedge clk);
      sample_stb = 1'b1;
      @(posedge clk);
      #1;
      sample_stb = 1'b0;
      chk("t6_wr", buf_we, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_async", buf_we, 0);
      chk("t6_rbusy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("t6_q", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
